fetch_queue: RTL and testbench

- Instruction queue between the instruction-fetch stage (PC + instruction memory) and the decode stage.
- Buffers {pc, instruction} pairs so decode can stall without losing fetched words, and lets fetch run ahead.
- Discards all buffered entries on a taken-branch redirect.
- First step in moving the single-cycle datapath toward a pipelined fetch/decode split.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_queue_mem.sv | 30 +++
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/decode instruction queue.
package fetch_pkg;

   localparam int FQ_DEPTH_DEFAULT = 4;
   localparam int ADDR_W           = 64;
   localparam int INSTR_W          = 32;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Unreset register array holding queued fetch entries; combinational read port.
module fetch_queue_mem
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = FQ_DEPTH_DEFAULT,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  entry_t                   wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output entry_t                   rd_data
);

   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_idx] = wr_data;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction FIFO with branch-redirect flush and sync active-low reset.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH_DEFAULT,
   parameter int AW    = ADDR_W,
   parameter int IW    = INSTR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [AW-1:0]          in_pc,
   input  logic [IW-1:0]          in_instr,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [AW-1:0]          out_pc,
   output logic [IW-1:0]          out_instr,
   input  logic                   out_ready,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } entry_t;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop, clear;
   entry_t        wr_data, rd_data;

   // Outputs are gated by reset so they read as idle while reset is held,
   // even before the first sampling edge has cleared the flops.
   always_comb begin
      in_ready  = reset && (count_q < CW'(DEPTH));
      out_valid = reset && (count_q != '0);
      count     = reset ? count_q : '0;
      out_pc    = out_valid ? rd_data.pc    : '0;
      out_instr = out_valid ? rd_data.instr : '0;
   end

   assign clear = !reset || flush;
   assign push  = in_valid && in_ready && !clear;
   assign pop   = out_valid && out_ready && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_data.pc    = in_pc;
   assign wr_data.instr = in_instr;

   fetch_queue_mem #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_idx  (wr_ptr_q),
      .wr_data (wr_data),
      .rd_idx  (rd_ptr_q),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios then randomized traffic.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 64;
   localparam int IW    = 32;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready, flush;
   logic [AW-1:0] in_pc, out_pc;
   logic [IW-1:0] in_instr, out_instr;
   logic [2:0]    count;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   ent_t        sb[$];

   fetch_queue #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .IW    (IW)
   ) dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .flush     (flush),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue of accepted entries; checked on the falling
   // edge, then advanced to reflect what the next rising edge will do.
   always @(negedge clk) begin
      bit   exp_rdy, exp_vld;
      ent_t head;
      exp_rdy = rst_n && (sb.size() < DEPTH);
      exp_vld = rst_n && (sb.size() != 0);
      check("in_ready",  64'(in_ready),  64'(exp_rdy));
      check("out_valid", 64'(out_valid), 64'(exp_vld));
      check("count",     64'(count),     rst_n ? 64'(sb.size()) : 64'd0);
      if (exp_vld) begin
         head = sb[0];
         check("out_pc",    out_pc,         head.pc);
         check("out_instr", 64'(out_instr), 64'(head.instr));
      end else begin
         check("out_pc_idle",    out_pc,         64'd0);
         check("out_instr_idle", 64'(out_instr), 64'd0);
      end
      if (!rst_n || flush) begin
         sb.delete();
      end else begin
         if (exp_vld && out_ready) void'(sb.pop_front());
         if (in_valid && exp_rdy) sb.push_back('{pc: in_pc, instr: in_instr});
      end
   end

   task automatic cyc(input bit v, input logic [AW-1:0] pc, input bit rdy, input bit fl);
      in_valid  = v;
      in_pc     = pc;
      in_instr  = 32'h9100_0000 + pc[31:0];
      out_ready = rdy;
      flush     = fl;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("reset_count", 64'(count), 64'd0);
      rst_n = 1'b1;

      // fill to full, then a refused fifth push
      for (int i = 0; i < 4; i++) cyc(1, 64'(i * 4), 0, 0);
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      cyc(1, 64'd16, 0, 0);
      check("full_hold_count", 64'(count), 64'd4);

      // drain in order
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
      check("drained_count", 64'(count), 64'd0);
      check("drained_pc", out_pc, 64'd0);

      // streaming through pointer wrap
      for (int i = 0; i < 20; i++) cyc(1, 64'(i * 4), 1, 0);
      check("stream_count", 64'(count), 64'd1);
      cyc(0, 0, 1, 0);

      // flush beats same-cycle push and pop
      for (int i = 0; i < 3; i++) cyc(1, 64'(40 + i * 4), 0, 0);
      check("pre_flush_count", 64'(count), 64'd3);
      cyc(1, 64'd100, 1, 1);
      check("post_flush_count", 64'(count), 64'd0);
      check("post_flush_valid", 64'(out_valid), 64'd0);
      cyc(1, 64'd200, 0, 0);
      check("after_flush_pc", out_pc, 64'd200);
      cyc(0, 0, 1, 0);

      // reset mid-stream
      cyc(1, 64'd500, 0, 0);
      cyc(1, 64'd504, 0, 0);
      rst_n = 1'b0;
      cyc(1, 64'd508, 0, 0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 64'(in_ready), 64'd1);
      cyc(1, 64'd600, 0, 0);
      check("rel_first_pc", out_pc, 64'd600);
      cyc(0, 0, 1, 0);

      // full boundary: pop and push together, push refused
      for (int i = 0; i < 4; i++) cyc(1, 64'(700 + i * 4), 0, 0);
      cyc(1, 64'd300, 1, 0);
      check("bnd_count", 64'(count), 64'd3);
      check("bnd_in_ready", 64'(in_ready), 64'd1);
      cyc(1, 64'd300, 0, 0);
      check("bnd_refill", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         cyc($urandom_range(0, 2) != 0, {$urandom, $urandom},
             $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
      check("final_empty", 64'(count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
